vec_addsub: RTL and testbench
=============================

VEC_ADDSUB -- requirements
Module: vec_addsub

Interface
REQ-001 Parameter LANES, default 2, number of independent lanes (1..8).
REQ-002 Parameter EW, default 24, lane element width; format sign[EW-1], exponent 8 bits (bias 127), fraction EW-9 bits.
REQ-003 Parameter PIPE, default 3, extra output delay stages after the arithmetic core (0..8).
REQ-004 Parameter FIFO_DEPTH, default 8, output FIFO entries (>=1).
REQ-005 clock  in  1  sole clock; all state updates on posedge.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 in_valid  in  1  input beat present.
REQ-008 in_ready  out  1  block accepts a beat this cycle.
REQ-009 in_op  in  1  0 = add (a+b), 1 = subtract (a-b), per beat.
REQ-010 in_mask  in  LANES  lane enable; 0 = lane bypass.
REQ-011 element1  in  LANES*EW  operand a; lane i at bits [i*EW +: EW].
REQ-012 element2  in  LANES*EW  operand b; same packing.
REQ-013 out_valid  out  1  FIFO head valid.
REQ-014 out_ready  in  1  consumer takes head.
REQ-015 new1  out  LANES*EW  result; same packing.

Function
REQ-016 Accept occurs when in_valid && in_ready; operands, op and mask are registered that cycle.
REQ-017 Each lane computes a (op) b with round-to-nearest-even (rnd code 0) in the existing addsub core, registered output.
REQ-018 Accepted beat reaches the FIFO write port LAT = 2 + PIPE cycles after accept; beats never reorder.
REQ-019 Masked-off lane outputs its operand a unchanged, delayed identically to enabled lanes.
REQ-020 A valid bit travels alongside data through all LAT stages; only valid stages write the FIFO.
REQ-021 Credit counter inflight = beats accepted but not yet written to FIFO (0..LAT).
REQ-022 in_ready = (inflight + fifo_count) < FIFO_DEPTH, driven from registers only; no combinational path from out_ready.
REQ-023 Pop occurs when out_valid && out_ready; the freed credit is visible in in_ready the next cycle.
REQ-024 Simultaneous FIFO write and pop: count unchanged; on an empty FIFO the written beat appears on out_valid the following cycle (no fall-through).
REQ-025 FIFO full cannot be overrun (guaranteed by REQ-022); pointers wrap modulo FIFO_DEPTH.
REQ-026 new1 holds the FIFO head and is stable while out_valid && !out_ready.
REQ-027 Full throughput (one beat per cycle, sustained) when FIFO_DEPTH >= LAT + 1 and out_ready stays high.

Reset
REQ-028 Reset clears pipeline valid bits, inflight, FIFO pointers and count; out_valid = 0, in_ready = 1, new1 = 0.
REQ-029 Reset mid-operation discards all in-flight and queued beats; no stale beat emerges after release.
REQ-030 Operand and pipeline data registers need no reset.

Structure
REQ-031 Package vec_addsub_pkg holds the format constants (exponent width 8, bias 127), op encodings OP_ADD = 0 and OP_SUB = 1, and a LAT(PIPE) function.
REQ-032 Sub-module vec_addsub_lane wraps one addsub core plus the operand-a bypass and PIPE delay line; instantiated LANES times via generate.
REQ-033 The credit counter, valid shift register and FIFO live in the top level.

Verification
REQ-034 Default params, lane0 a=0x404000 (3.0), b=0x3F8000 (1.0), op=1, mask=11 -> new1 lane0 = 0x400000 (2.0), out_valid 5 cycles after accept.
REQ-035 a=b=0x3F8000, op=1 -> lane result 0x000000; op=0 -> 0x400000.
REQ-036 mask=01, lane1 a=0x123456 -> lane1 output 0x123456 regardless of op or b.
REQ-037 out_ready=0, 20 back-to-back beats -> exactly 8 accepted, in_ready low thereafter; then release out_ready -> 8 beats drain in order and in_ready reasserts one cycle after the first pop.
REQ-038 Assert reset with 3 beats in flight and 2 queued -> out_valid = 0 next cycle and no output for 10 cycles after release.

Source files
------------

// File: rtl/vec_addsub_pkg.sv
// vec_addsub_pkg
// Shared constants for the vec_addsub slice: element format (8-bit exponent,
// bias 127), op encodings and the accept-to-FIFO latency helper.
package vec_addsub_pkg;

   localparam int EXP_W   = 8;
   localparam int BIAS    = 127;
   localparam int EXP_MAX = 2 * BIAS + 1;   // all-ones exponent, used for overflow

   typedef enum logic {
      OP_ADD = 1'b0,
      OP_SUB = 1'b1
   } op_e;

   // Input register + registered core output + PIPE delay stages.
   function automatic int lat(input int pipe);
      return 2 + pipe;
   endfunction

endpackage

// File: rtl/vec_addsub_lane.sv
// vec_addsub_lane
// One lane: operand registers (loaded on accept), floating-point add/sub core
// with round-to-nearest-even and a registered result, operand-a bypass for
// masked-off lanes, then a PIPE-deep delay line.
// Ports:
//   clock        sole clock
//   load         capture op/mask/a/b this cycle (beat accepted)
//   op           OP_ADD / OP_SUB
//   mask         1 = compute, 0 = pass a through
//   a, b         operands (sign | exp[8] | frac[EW-9])
//   result       lane output, 2+PIPE cycles after load
module vec_addsub_lane
   import vec_addsub_pkg::*;
#(
   parameter int EW   = 24,
   parameter int PIPE = 3
) (
   input  logic          clock,
   input  logic          load,
   input  op_e           op,
   input  logic          mask,
   input  logic [EW-1:0] a,
   input  logic [EW-1:0] b,
   output logic [EW-1:0] result
);

   localparam int FW = EW - EXP_W - 1;   // stored fraction bits
   localparam int M  = FW + 1;           // mantissa with hidden bit
   localparam int XW = M + 3;            // plus guard/round/sticky
   localparam int SW = XW + 1;           // plus carry

   logic [EW-1:0]      a_q, b_q, core_q, res;
   op_e                op_q;
   logic               mask_q;

   logic [EXP_W-1:0]   ea, eb, el, es;
   logic [M-1:0]       ma, mb, ml, ms;
   logic               sa, sb, sgn, swap, eff_sub;
   logic [XW-1:0]      xl, xs, sh, lost;
   logic [SW-1:0]      sum, norm;
   logic signed [EXP_W+1:0] e;
   logic [M:0]         mant;
   logic               inc;
   int                 d, lz;

   always_ff @(posedge clock) begin
      if (load) begin
         a_q    <= a;
         b_q    <= b;
         op_q   <= op;
         mask_q <= mask;
      end
   end

   always_comb begin
      ea   = a_q[EW-2 -: EXP_W];
      eb   = b_q[EW-2 -: EXP_W];
      sa   = a_q[EW-1];
      sb   = b_q[EW-1] ^ (op_q == OP_SUB);
      // zero exponent is treated as zero (denormals flushed)
      ma   = (ea == '0) ? '0 : {1'b1, a_q[FW-1:0]};
      mb   = (eb == '0) ? '0 : {1'b1, b_q[FW-1:0]};
      swap = b_q[EW-2:0] > a_q[EW-2:0];
      el   = swap ? eb : ea;
      es   = swap ? ea : eb;
      ml   = swap ? mb : ma;
      ms   = swap ? ma : mb;
      sgn  = swap ? sb : sa;
      eff_sub = sa ^ sb;

      d    = int'(el) - int'(es);
      xl   = {ml, 3'b000};
      xs   = {ms, 3'b000};
      lost = '0;
      if (d >= XW) begin
         sh    = '0;
         sh[0] = |xs;
      end else begin
         sh    = xs >> d;
         lost  = xs << (XW - d);
         sh[0] = sh[0] | (|lost);
      end

      sum = eff_sub ? ({1'b0, xl} - {1'b0, sh}) : ({1'b0, xl} + {1'b0, sh});
      e   = signed'({2'b00, el});
      lz  = 0;
      if (sum[SW-1]) begin
         norm    = {1'b0, sum[SW-1:1]};
         norm[0] = sum[1] | sum[0];
         e       = e + 1'b1;
      end else begin
         for (int i = 0; i < SW - 1; i++) begin
            if (lz == i && !sum[SW-2-i]) lz = i + 1;
         end
         norm = sum << lz;
         e    = e - (EXP_W+2)'(lz);
      end

      // round to nearest, ties to even
      inc  = norm[2] & (norm[1] | norm[0] | norm[3]);
      mant = {1'b0, norm[SW-2:3]} + (M+1)'(inc);
      if (mant[M]) begin
         mant = mant >> 1;
         e    = e + 1'b1;
      end

      if (sum == '0 || e <= 0)
         res = '0;
      else if (e >= EXP_MAX)
         res = {sgn, EXP_W'(EXP_MAX), {FW{1'b0}}};
      else
         res = {sgn, e[EXP_W-1:0], mant[FW-1:0]};
   end

   always_ff @(posedge clock) begin
      core_q <= mask_q ? res : a_q;
   end

   generate
      if (PIPE == 0) begin : g_nopipe
         assign result = core_q;
      end else begin : g_pipe
         logic [EW-1:0] dly_q [PIPE];
         always_ff @(posedge clock) begin
            dly_q[0] <= core_q;
            for (int i = 1; i < PIPE; i++) dly_q[i] <= dly_q[i-1];
         end
         assign result = dly_q[PIPE-1];
      end
   endgenerate

endmodule

// File: rtl/vec_addsub.sv
// vec_addsub
// LANES-wide floating-point add/subtract stream with credit-based flow
// control and an output FIFO. in_ready depends only on registered state.
// Ports:
//   clock, reset         clock; asynchronous active-high reset
//   in_valid/in_ready    input handshake
//   in_op, in_mask       per-beat op and lane enables
//   element1, element2   packed operands a and b (lane i at [i*EW +: EW])
//   out_valid/out_ready  output handshake (FIFO head)
//   new1                 packed result (FIFO head, 0 when empty)
module vec_addsub
   import vec_addsub_pkg::*;
#(
   parameter int LANES      = 2,
   parameter int EW         = 24,
   parameter int PIPE       = 3,
   parameter int FIFO_DEPTH = 8
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic                in_op,
   input  logic [LANES-1:0]    in_mask,
   input  logic [LANES*EW-1:0] element1,
   input  logic [LANES*EW-1:0] element2,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [LANES*EW-1:0] new1
);

   localparam int L  = lat(PIPE);
   localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = $clog2(L + FIFO_DEPTH + 1);

   logic                acc, wr, pop;
   logic [L-1:0]        vld;
   logic [CW-1:0]       inflight, count;
   logic [PW-1:0]       wr_ptr, rd_ptr;
   logic [LANES*EW-1:0] lane_res;
   logic [LANES*EW-1:0] mem [FIFO_DEPTH];

   assign acc       = in_valid & in_ready;
   assign wr        = vld[L-1];
   assign out_valid = (count != '0);
   assign pop       = out_valid & out_ready;
   assign in_ready  = (inflight + count) < CW'(FIFO_DEPTH);
   assign new1      = out_valid ? mem[rd_ptr] : '0;

   generate
      for (genvar i = 0; i < LANES; i++) begin : g_lane
         vec_addsub_lane #(.EW(EW), .PIPE(PIPE)) u_lane (
            .clock  (clock),
            .load   (acc),
            .op     (op_e'(in_op)),
            .mask   (in_mask[i]),
            .a      (element1[i*EW +: EW]),
            .b      (element2[i*EW +: EW]),
            .result (lane_res[i*EW +: EW])
         );
      end
   endgenerate

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         vld      <= '0;
         inflight <= '0;
         count    <= '0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
      end else begin
         vld <= {vld[L-2:0], acc};
         if (acc && !wr)      inflight <= inflight + 1'b1;
         else if (!acc && wr) inflight <= inflight - 1'b1;
         if (wr && !pop)      count <= count + 1'b1;
         else if (!wr && pop) count <= count - 1'b1;
         if (wr) wr_ptr <= (wr_ptr == PW'(FIFO_DEPTH-1)) ? '0 : wr_ptr + 1'b1;
         if (pop) rd_ptr <= (rd_ptr == PW'(FIFO_DEPTH-1)) ? '0 : rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (wr) mem[wr_ptr] <= lane_res;
   end

endmodule

// File: tb/tb_vec_addsub.sv
// tb_vec_addsub
// Directed vector table for the arithmetic and latency, plus hand-written
// sequences for FIFO back-pressure/drain and reset with beats in flight.
module tb_vec_addsub;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic        in_op = 1'b0;
   logic [1:0]  in_mask = 2'b11;
   logic [47:0] element1 = '0;
   logic [47:0] element2 = '0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [47:0] new1;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clock = ~clock;

   vec_addsub dut (
      .clock     (clock),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_op     (in_op),
      .in_mask   (in_mask),
      .element1  (element1),
      .element2  (element2),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .new1      (new1)
   );

   typedef struct {
      logic [23:0] a0, b0, a1, b1;
      logic        op;
      logic [1:0]  mask;
      logic [23:0] e0, e1;
   } vec_t;

   vec_t tv [8];

   task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int cyc, acc_cnt, k;
      logic bad;

      tv[0] = '{24'h404000, 24'h3F8000, 24'h3F8000, 24'h3F8000, 1'b1, 2'b11, 24'h400000, 24'h000000};
      tv[1] = '{24'h3F8000, 24'h3F8000, 24'h3F8000, 24'h400000, 1'b0, 2'b11, 24'h400000, 24'h404000};
      tv[2] = '{24'h404000, 24'hBF8000, 24'h3F8000, 24'hC00000, 1'b0, 2'b11, 24'h400000, 24'hBF8000};
      tv[3] = '{24'h3FC000, 24'h3F0000, 24'h123456, 24'h3F8000, 1'b0, 2'b01, 24'h400000, 24'h123456};
      tv[4] = '{24'h3F8000, 24'h400000, 24'h123456, 24'h7FFFFF, 1'b1, 2'b01, 24'hBF8000, 24'h123456};
      tv[5] = '{24'h3F8000, 24'h378000, 24'h3F8001, 24'h378000, 1'b0, 2'b11, 24'h3F8000, 24'h3F8002};
      tv[6] = '{24'hABCDEF, 24'h3F8000, 24'h000001, 24'h3F8000, 1'b1, 2'b00, 24'hABCDEF, 24'h000001};
      tv[7] = '{24'h3F8001, 24'h3F8000, 24'h400000, 24'h404000, 1'b1, 2'b11, 24'h380000, 24'hBF8000};

      // reset state
      repeat (2) @(posedge clock);
      #1;
      chk("rst_out_valid", 48'(out_valid), 48'd0);
      chk("rst_in_ready", 48'(in_ready), 48'd1);
      chk("rst_new1", new1, 48'd0);
      @(negedge clock);
      reset = 1'b0;

      // table: one beat at a time, latency and per-lane results
      for (int i = 0; i < 8; i++) begin
         @(negedge clock);
         chk($sformatf("v%0d_in_ready", i), 48'(in_ready), 48'd1);
         in_valid = 1'b1;
         in_op    = tv[i].op;
         in_mask  = tv[i].mask;
         element1 = {tv[i].a1, tv[i].a0};
         element2 = {tv[i].b1, tv[i].b0};
         @(posedge clock);
         #1;
         in_valid = 1'b0;
         cyc = 0;
         while (cyc < 20) begin
            @(posedge clock);
            #1;
            cyc++;
            if (out_valid) break;
         end
         chk($sformatf("v%0d_latency", i), 48'(cyc), 48'd5);
         chk($sformatf("v%0d_lane0", i), 48'(new1[23:0]), 48'(tv[i].e0));
         chk($sformatf("v%0d_lane1", i), 48'(new1[47:24]), 48'(tv[i].e1));
         @(posedge clock);
         #1;
         chk($sformatf("v%0d_popped", i), 48'(out_valid), 48'd0);
      end

      // back-pressure: 20 offered beats, FIFO_DEPTH accepted
      @(negedge clock);
      out_ready = 1'b0;
      in_mask   = 2'b00;
      acc_cnt   = 0;
      for (int i = 0; i < 20; i++) begin
         element1 = {24'h200000 + 24'(i), 24'h100000 + 24'(i)};
         in_valid = 1'b1;
         if (in_ready) acc_cnt++;
         @(negedge clock);
      end
      in_valid = 1'b0;
      chk("bp_accepted", 48'(acc_cnt), 48'd8);
      repeat (10) @(negedge clock);
      chk("bp_in_ready_low", 48'(in_ready), 48'd0);
      chk("bp_out_valid", 48'(out_valid), 48'd1);
      chk("bp_head_stable", new1, {24'h200000, 24'h100000});
      @(negedge clock);
      chk("bp_head0", new1, {24'h200000, 24'h100000});
      out_ready = 1'b1;
      @(posedge clock);
      #1;
      chk("bp_in_ready_reassert", 48'(in_ready), 48'd1);
      k = 1;
      for (int c = 0; c < 30 && k < 8; c++) begin
         @(negedge clock);
         if (out_valid) begin
            chk($sformatf("bp_drain%0d", k), new1, {24'h200000 + 24'(k), 24'h100000 + 24'(k)});
            k++;
         end
      end
      chk("bp_drain_count", 48'(k), 48'd8);
      @(negedge clock);
      chk("bp_empty", 48'(out_valid), 48'd0);

      // reset with 2 queued and 3 in flight
      out_ready = 1'b0;
      in_mask   = 2'b11;
      in_op     = 1'b0;
      element1  = {24'h3F8000, 24'h3F8000};
      element2  = {24'h3F8000, 24'h3F8000};
      in_valid  = 1'b1;
      repeat (2) @(negedge clock);
      in_valid  = 1'b0;
      repeat (8) @(negedge clock);
      chk("rq_queued", 48'(out_valid), 48'd1);
      in_valid = 1'b1;
      repeat (3) @(negedge clock);
      in_valid = 1'b0;
      reset    = 1'b1;
      @(posedge clock);
      #1;
      chk("rq_out_valid", 48'(out_valid), 48'd0);
      chk("rq_in_ready", 48'(in_ready), 48'd1);
      chk("rq_new1", new1, 48'd0);
      @(negedge clock);
      reset     = 1'b0;
      out_ready = 1'b1;
      bad = 1'b0;
      repeat (10) begin
         @(negedge clock);
         if (out_valid) bad = 1'b1;
      end
      chk("rq_no_stale", 48'(bad), 48'd0);

      // one fresh beat after reset still works
      in_op    = 1'b1;
      element1 = {24'h3F8000, 24'h404000};
      element2 = {24'h3F8000, 24'h3F8000};
      in_valid = 1'b1;
      @(posedge clock);
      #1;
      in_valid = 1'b0;
      cyc = 0;
      while (cyc < 20) begin
         @(posedge clock);
         #1;
         cyc++;
         if (out_valid) break;
      end
      chk("post_latency", 48'(cyc), 48'd5);
      chk("post_result", new1, {24'h000000, 24'h400000});

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
